exp_golomb_encoder: RTL and testbench
=====================================

// Module: exp_golomb_encoder
// PURPOSE
//  Order-0 Exp-Golomb encoder: the stage directly upstream of the EGD decoder.
//  Accepts 4-bit symbols over a valid/ready handshake and buffers them in a small FIFO.
//  Serialises each symbol as a codeword: N zeros, then (v+1) in N+1 bits MSB-first,
//  where N = floor(log2(v+1)).
//  Output is a 1-bit stream that honours the decoder's busy as a stall.
// PARAMETERS
//  DATA_W      4   symbol width; max codeword length = 2*DATA_W+1 (9)
//  FIFO_DEPTH  4   input FIFO entries, power of 2, >=2
//  CNT_W       16  width of the codeword counter
// PORTS
//  clk       in   1        single clock, rising edge
//  rst       in   1        synchronous, active-high reset
//  in_valid  in   1        in_data is presented
//  in_data   in   DATA_W   symbol value v
//  in_ready  out  1        FIFO can accept; a write occurs on an edge with in_valid&in_ready
//  so_data   out  1        serial code bit
//  so_valid  out  1        so_data is meaningful
//  so_last   out  1        current bit is the final bit of its codeword
//  so_stall  in   1        downstream busy; hold the current bit
//  cw_cnt    out  CNT_W    codewords fully emitted; wraps
// BEHAVIOUR
//  Reset (sync, active-high, clk/rst as named above):
//   - FIFO emptied; serializer idle.
//   - so_data=0, so_valid=0, so_last=0, cw_cnt=0.
//   - in_ready=0 while rst is high, then 1 the cycle after release.
//   - Reset mid-codeword abandons the codeword; no partial bits follow.
//  in_ready = ~fifo_full & ~rst.
//   - A write and a pop in the same edge on a full FIFO are legal; the count is unchanged.
//  Bit consumption: a bit is consumed on an edge where so_valid & ~so_stall.
//   - While so_stall=1: so_data, so_valid, so_last and the internal state are frozen.
//  FSM:
//   - IDLE: so_valid=0. If the FIFO is non-empty, pop, compute N and the code, go to EMIT.
//   - EMIT: so_valid=1. Load a shift register {N zeros, v+1} left-justified, with remaining count len=2N+1.
//     Each consumed bit shifts and decrements len. so_last = (len==1).
//   - Last bit consumed: cw_cnt+1. If the FIFO is non-empty, pop and reload in the same edge:
//     no bubble, and so_valid stays 1. Otherwise go to IDLE.
//  Latency: a symbol written at edge t into an empty FIFO with an idle serializer
//   drives its first bit from edge t+1, valid during cycle t+1..t+2.
//  Capacity with a permanent stall: FIFO_DEPTH in the FIFO + 1 in the serializer.
//  Arithmetic:
//   - v+1 is computed in DATA_W+1 bits, so v=15 gives 5'b10000.
//   - N is a priority encode of v+1; len uses a 4-bit field.
//   - cw_cnt wraps 2^CNT_W-1 -> 0.
//  Simultaneous events:
//   - A write to an empty FIFO on the same edge as the IDLE check is not visible until the next edge.
//   - A pop plus a write on a full FIFO keeps in_ready=0 only when the count stays full.
// STRUCTURE
//  Package ego_pkg holds:
//   - DATA_W default, MAX_CW_LEN = 2*DATA_W+1, LEN_W;
//   - state enum {S_IDLE, S_EMIT};
//   - function prefix_len(v+1).
//  Sub-module sync_fifo (rd/wr ptr + count, sync reset) holds the input FIFO.
//  The FSM and shift register stay in this module.
// TESTING
//  1) v=0, no stall -> so_data 1 for one cycle, so_last=1, cw_cnt=1.
//  2) v=3 -> 0,0,1,0,0 on consecutive cycles; so_last only on the 5th.
//     v=15 -> 0000 10000 (9 bits).
//  3) Back-to-back 0,1,2 -> stream 1|010|011.
//     so_valid high 7 consecutive cycles; so_last on bits 1, 4 and 7; cw_cnt=3.
//  4) v=5 (00110) with so_stall high for 3 cycles while bit 3 is shown:
//     so_data=1 and so_valid=1 held for 4 cycles, then 1,0 follow; no bit lost or duplicated.
//  5) so_stall held high, in_valid pushing 0..7:
//     exactly 5 symbols are accepted, then in_ready=0.
//     Releasing the stall emits codes for 0..4 in order, and in_ready returns.
//  6) rst pulsed during bit 4 of v=15:
//     next cycle so_valid=0 and cw_cnt=0.
//     A new v=1 afterwards emits 010 cleanly.
//     Loopback into EGD with 512 random symbols gives 0 mismatches.

Source files
------------

// File: rtl/ego_pkg.sv
// Shared constants, FSM state type and prefix-length helper for the Exp-Golomb encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ego_pkg;

    localparam int DATA_W     = 4;
    localparam int MAX_CW_LEN = 2 * DATA_W + 1;
    localparam int LEN_W      = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // Number of leading zeros in the codeword: floor(log2(code)), code = v+1 (never zero).
    function automatic logic [LEN_W-1:0] prefix_len(input logic [DATA_W:0] code);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i <= DATA_W; i++) begin
            if (code[i]) begin
                n = LEN_W'(i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Latency: a write is visible on rd_data/empty the cycle after the writing edge.
// Backpressure: full blocks writes unless a read happens on the same edge; reads on empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a simultaneous read frees a slot for a write on a full FIFO.
    always_comb begin
        do_rd    = rd_en & ~empty;
        do_wr    = wr_en & (~full | do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/exp_golomb_encoder.sv
// Order-0 Exp-Golomb encoder: buffered symbols serialised as N zeros then (v+1) MSB-first.
// Latency: first code bit driven one edge after the symbol is written into an empty FIFO.
// Backpressure: in_ready drops when the FIFO is full; so_stall freezes the current bit and state.
module exp_golomb_encoder #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              so_data,
    output logic              so_valid,
    output logic              so_last,
    input  logic              so_stall,
    output logic [CNT_W-1:0]  cw_cnt
);

    import ego_pkg::*;

    localparam int SR_W = 2 * DATA_W + 1;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cw_cnt_q, cw_cnt_d;

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [DATA_W:0]   code;
    logic [LEN_W-1:0]  code_n;
    logic [SR_W-1:0]   load_sr;
    logic [LEN_W-1:0]  load_len;

    assign in_ready = ~fifo_full & ~rst;
    assign so_valid = (state_q == S_EMIT);
    assign so_data  = so_valid & sr_q[SR_W-1];
    assign so_last  = so_valid & (len_q == LEN_W'(1));
    assign cw_cnt   = cw_cnt_q;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid & in_ready),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Codeword for the FIFO head: v+1 sits in the low 2N+1 bits, its upper N bits are
    // the zero prefix, so shifting up left-justifies the whole codeword at the MSB.
    always_comb begin
        code     = (DATA_W+1)'(fifo_rd_data) + (DATA_W+1)'(1);
        code_n   = prefix_len(code);
        load_sr  = SR_W'(code) << (SR_W - 1 - 2 * int'(code_n));
        load_len = LEN_W'(2 * int'(code_n) + 1);
    end

    // Next-state: load from FIFO when idle, shift on each consumed bit, reload back-to-back.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        len_d    = len_q;
        cw_cnt_d = cw_cnt_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sr_d    = load_sr;
                    len_d   = load_len;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (!so_stall) begin
                    if (len_q == LEN_W'(1)) begin
                        cw_cnt_d = cw_cnt_q + 1'b1;
                        if (!fifo_empty) begin
                            pop   = 1'b1;
                            sr_d  = load_sr;
                            len_d = load_len;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        sr_d  = sr_q << 1;
                        len_d = len_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Serializer state register; reset abandons any codeword in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            len_q    <= '0;
            cw_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            len_q    <= len_d;
            cw_cnt_q <= cw_cnt_d;
        end
    end

endmodule

// File: tb/tb_exp_golomb_encoder.sv
// Self-checking bench for exp_golomb_encoder: fixed vectors, corner sequences, random run vs model.
// Latency: n/a.
// Backpressure: exercised through so_stall and a full input FIFO.
module tb_exp_golomb_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_ready;
    logic        so_data;
    logic        so_valid;
    logic        so_last;
    logic        so_stall;
    logic [15:0] cw_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cw = 0;

    typedef struct {
        int         v;
        int         len;
        logic [8:0] bits;
    } vec_t;

    vec_t tbl[6];

    bit mq[$];
    bit ml[$];

    logic [8:0] got;
    int         nb;
    bit         fin;

    exp_golomb_encoder #(
        .DATA_W     (4),
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .so_data  (so_data),
        .so_valid (so_valid),
        .so_last  (so_last),
        .so_stall (so_stall),
        .cw_cnt   (cw_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference codeword: N = floor(log2(v+1)) zeros, then v+1 in N+1 bits MSB-first.
    task automatic model_push(input int v);
        int c;
        int n;
        c = v + 1;
        n = 0;
        while ((c >> (n + 1)) != 0) n++;
        for (int i = 0; i < n; i++) begin
            mq.push_back(1'b0);
            ml.push_back(1'b0);
        end
        for (int i = n; i >= 0; i--) begin
            mq.push_back(((c >> i) & 1) != 0);
            ml.push_back(i == 0);
        end
    endtask

    task automatic push(input int v);
        int w;
        in_valid = 1'b1;
        in_data  = 4'(v);
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("push_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(output logic [8:0] bits, output int n, output bit done);
        bits = '0;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (so_valid) begin
                bits = {bits[7:0], so_data};
                n++;
                done = so_last;
            end
            tick();
        end
        chk("collect_done", int'(done), 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        so_stall = 1'b0;

        tbl[0] = '{0,  1, 9'b000000001};
        tbl[1] = '{3,  5, 9'b000000100};
        tbl[2] = '{15, 9, 9'b000010000};
        tbl[3] = '{1,  3, 9'b000000010};
        tbl[4] = '{6,  5, 9'b000000111};
        tbl[5] = '{8,  7, 9'b000001001};

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_so_valid", int'(so_valid), 0);
        chk("rst_so_data",  int'(so_data), 0);
        chk("rst_so_last",  int'(so_last), 0);
        chk("rst_cw_cnt",   int'(cw_cnt), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Single codewords from the table
        for (int i = 0; i < 6; i++) begin
            push(tbl[i].v);
            collect(got, nb, fin);
            exp_cw++;
            chk($sformatf("tbl%0d_len", i), nb, tbl[i].len);
            chk($sformatf("tbl%0d_bits", i), int'(got), int'(tbl[i].bits));
            chk($sformatf("tbl%0d_cw", i), int'(cw_cnt), exp_cw);
            tick();
        end

        // Back-to-back 0,1,2: no bubble between codewords
        begin
            logic [6:0] s;
            int n;
            int run;
            int maxrun;
            int lastmask;
            s = '0; n = 0; run = 0; maxrun = 0; lastmask = 0;
            for (int c = 0; c < 20; c++) begin
                in_valid = (c < 3);
                in_data  = 4'(c);
                if (so_valid) begin
                    s = {s[5:0], so_data};
                    n++;
                    run++;
                    if (run > maxrun) maxrun = run;
                    if (so_last) lastmask = lastmask | (1 << (n - 1));
                end else begin
                    run = 0;
                end
                tick();
            end
            in_valid = 1'b0;
            exp_cw += 3;
            chk("b2b_bits", int'(s), 7'b1010011);
            chk("b2b_nbits", n, 7);
            chk("b2b_run", maxrun, 7);
            chk("b2b_lastpos", lastmask, 7'b1001001);
            chk("b2b_cw", int'(cw_cnt), exp_cw);
        end

        // Stall on bit 3 of v=5
        begin
            logic [4:0] s;
            int consumed;
            int stallcnt;
            int held;
            int dbad;
            bit done;
            s = '0; consumed = 0; stallcnt = 0; held = 0; dbad = 0; done = 1'b0;
            push(5);
            for (int c = 0; c < 30 && !done; c++) begin
                so_stall = so_valid && consumed == 2 && stallcnt < 3;
                if (so_stall) stallcnt++;
                if (so_valid && consumed == 2) begin
                    held++;
                    if (!so_data) dbad++;
                end
                if (so_valid && !so_stall) begin
                    s = {s[3:0], so_data};
                    consumed++;
                    done = so_last;
                end
                tick();
            end
            so_stall = 1'b0;
            exp_cw++;
            chk("stall_bits", int'(s), 5'b00110);
            chk("stall_nbits", consumed, 5);
            chk("stall_held", held, 4);
            chk("stall_data_held", dbad, 0);
            chk("stall_cw", int'(cw_cnt), exp_cw);
        end

        // Permanent stall: capacity is FIFO depth plus one in the serializer
        begin
            int nxt;
            bit acc;
            int mism;
            int cons;
            nxt = 0;
            so_stall = 1'b1;
            for (int c = 0; c < 12; c++) begin
                in_valid = (nxt < 8);
                in_data  = 4'(nxt);
                acc = in_valid && in_ready;
                tick();
                if (acc) nxt++;
            end
            in_valid = 1'b0;
            chk("cap_accepted", nxt, 5);
            chk("cap_in_ready", int'(in_ready), 0);
            mq.delete();
            ml.delete();
            for (int v = 0; v < 5; v++) model_push(v);
            so_stall = 1'b0;
            mism = 0;
            cons = 0;
            for (int c = 0; c < 60 && mq.size() != 0; c++) begin
                if (so_valid) begin
                    if (mq.pop_front() != so_data) mism++;
                    if (ml.pop_front() != so_last) mism++;
                    cons++;
                end
                tick();
            end
            exp_cw += 5;
            chk("cap_mismatch", mism, 0);
            chk("cap_nbits", cons, 17);
            chk("cap_in_ready_back", int'(in_ready), 1);
            chk("cap_cw", int'(cw_cnt), exp_cw);
        end

        // Reset during bit 4 of v=15
        begin
            int consumed;
            bit hit;
            consumed = 0;
            hit = 1'b0;
            push(15);
            for (int c = 0; c < 30 && !hit; c++) begin
                if (so_valid && consumed == 3) begin
                    rst = 1'b1;
                    tick();
                    chk("midrst_so_valid", int'(so_valid), 0);
                    chk("midrst_cw_cnt", int'(cw_cnt), 0);
                    chk("midrst_in_ready", int'(in_ready), 0);
                    rst = 1'b0;
                    hit = 1'b1;
                end else begin
                    if (so_valid) consumed++;
                    tick();
                end
            end
            chk("midrst_reached", int'(hit), 1);
            exp_cw = 0;
            tick();
            chk("midrst_idle", int'(so_valid), 0);
            push(1);
            collect(got, nb, fin);
            exp_cw++;
            chk("midrst_v1_bits", int'(got), 3'b010);
            chk("midrst_v1_len", nb, 3);
            chk("midrst_v1_cw", int'(cw_cnt), exp_cw);
        end

        // Random traffic and stalls against the reference model
        begin
            int sent;
            int mism;
            int cyc;
            sent = 0;
            mism = 0;
            cyc  = 0;
            mq.delete();
            ml.delete();
            while (cyc < 20000 && !(sent == 512 && mq.size() == 0)) begin
                in_valid = (sent < 512) && ($urandom_range(0, 3) != 0);
                in_data  = 4'($urandom_range(0, 15));
                so_stall = ($urandom_range(0, 3) == 0);
                if (in_valid && in_ready) begin
                    model_push(int'(in_data));
                    sent++;
                    exp_cw++;
                end
                if (so_valid && !so_stall) begin
                    if (mq.size() == 0) begin
                        mism++;
                    end else begin
                        if (mq.pop_front() != so_data) mism++;
                        if (ml.pop_front() != so_last) mism++;
                    end
                end
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            so_stall = 1'b0;
            chk("rand_sent", sent, 512);
            chk("rand_mismatch", mism, 0);
            chk("rand_drained", mq.size(), 0);
            chk("rand_cw", int'(cw_cnt), exp_cw);
            tick();
            chk("rand_idle", int'(so_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
